hero_write_rx: RTL
==================

HERO_WRITE_RX -- requirements
Module: hero_write_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: beat buffer entries, power of two, at least 2.
REQ-002 SHALL have parameter MAX_BEATS, default 16: maximum beats per transaction, power of two.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port hero_wr, input, hero_write_t (46 bits): incoming hero write bus beat.
REQ-006 SHALL have port hero_rdy, output, 1: receiver can accept a beat this cycle.
REQ-007 SHALL have port rx_vld, output, 1: buffered beat available.
REQ-008 SHALL have port rx_rdy, input, 1: downstream accepts the buffered beat.
REQ-009 SHALL have port rx_dat, output, HERO_WIDTH (36): beat write data.
REQ-010 SHALL have port rx_sub, output, sub_def_t (7): sub-field captured on the transaction's first beat.
REQ-011 SHALL have port rx_idx, output, clog2(MAX_BEATS): beat index within the transaction.
REQ-012 SHALL have port rx_last, output, 1: final beat of the transaction.
REQ-013 SHALL have port err_vld, output, 1: one-cycle protocol error pulse.
REQ-014 SHALL have port err_code, output, HERO_RX_ERR_E: error cause, held until the next error.
REQ-015 SHALL have port txn_cnt, output, 16: completed transactions, saturating at 16'hFFFF.

Function
REQ-016 SHALL accept a beat when hero_rdy=1, hero_wr.clk_en=1 and cycle_type is VALID or DONE; clk_en=0 or IDLE is a bubble.
REQ-017 SHALL drive hero_rdy=1 iff FIFO occupancy (registered) < FIFO_DEPTH; the sender holds the beat while hero_rdy=0.
REQ-018 SHALL run FSM states IDLE and XFER: an accepted VALID moves IDLE->XFER; an accepted DONE returns XFER->IDLE; an accepted DONE in IDLE is a single-beat transaction that stays in IDLE.
REQ-019 SHALL allow bubbles in XFER without leaving XFER.
REQ-020 SHALL capture another_type_reference on the first beat and output it as rx_sub on every beat of that transaction.
REQ-021 SHALL assign rx_idx from a beat counter: 0 on the first beat, incremented per accepted beat, cleared on last.
REQ-022 SHALL set rx_last on the DONE beat.
REQ-023 SHALL treat a VALID beat at index MAX_BEATS-1 as last, return to IDLE and raise err_vld with ERR_OVERLONG.
REQ-024 SHALL raise err_vld with ERR_SUB_MISMATCH when a non-first beat's another_type_reference differs from the captured value; the beat is buffered with the captured rx_sub.
REQ-025 SHALL raise err_vld one cycle after the offending beat is accepted.
REQ-026 SHALL make a beat accepted in cycle N visible on rx_vld in cycle N+1 (show-ahead FIFO).
REQ-027 SHALL hold rx_dat, rx_sub, rx_idx and rx_last stable while rx_vld=1 and rx_rdy=0.
REQ-028 SHALL pop on rx_vld and rx_rdy; simultaneous push and pop SHALL leave occupancy unchanged, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 SHALL increment txn_cnt when a last beat is popped downstream.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-transaction, asynchronously return the FSM to IDLE and clear the FIFO, beat counter, captured sub and txn_cnt.
REQ-031 SHALL hold these values during reset: hero_rdy=0, rx_vld=0, rx_dat=0, rx_sub=0, rx_idx=0, rx_last=0, err_vld=0, err_code=ERR_NONE, txn_cnt=0.
REQ-032 SHALL drive hero_rdy=1 in the first cycle after reset deassertion.
REQ-033 SHALL discard any partial transaction at reset, with no error reported.

Structure
REQ-034 SHALL place in the shared package: HERO_RX_ERR_E {ERR_NONE, ERR_OVERLONG, ERR_SUB_MISMATCH}, the hero_rx_entry_t struct (dat, sub, idx, last), and the FIFO_DEPTH and MAX_BEATS defaults as localparams.
REQ-035 SHALL instantiate a single sub-module, hero_rx_fifo, as a generic show-ahead synchronous FIFO of hero_rx_entry_t.

Verification
REQ-036 SHALL test: VALID(0x1), VALID(0x2), DONE(0x3), sub=7'h05, rx_rdy=1 -> three beats idx 0,1,2, last on idx 2, rx_sub=7'h05, txn_cnt=1.
REQ-037 SHALL test: a single DONE(0xABC) in IDLE -> one beat with idx=0, last=1; FSM stays IDLE.
REQ-038 SHALL test: rx_rdy=0 with 5 VALID beats -> hero_rdy=0 after 4 accepted; the 5th is held and accepted one cycle after rx_rdy=1.
REQ-039 SHALL test: 16 VALID beats -> beat idx 15 has last=1, err_vld pulses once with ERR_OVERLONG, FSM returns to IDLE.
REQ-040 SHALL test: a second beat with sub=7'h06 after first sub=7'h05 -> ERR_SUB_MISMATCH pulse and rx_sub=7'h05 on both beats.
REQ-041 SHALL test: rst_n low after 2 VALID beats -> rx_vld=0 and txn_cnt=0; a following DONE yields idx 0.

Source files
------------

// File: rtl/hero_write_rx_pkg.sv
// Shared types for the hero write receiver: bus beat layout, buffered entry,
// error causes and default sizing.
package hero_write_rx_pkg;

  localparam int HERO_WIDTH      = 36;
  localparam int SUB_WIDTH       = 7;
  localparam int HERO_FIFO_DEPTH = 4;
  localparam int HERO_MAX_BEATS  = 16;
  // Wide enough for any practical MAX_BEATS; the top uses only the low bits.
  localparam int IDX_FIELD_W     = 16;

  typedef logic [SUB_WIDTH-1:0] sub_def_t;

  typedef enum logic [1:0] {
    HERO_IDLE  = 2'd0,
    HERO_VALID = 2'd1,
    HERO_DONE  = 2'd2
  } hero_cycle_e;

  typedef struct packed {
    logic                  clk_en;
    hero_cycle_e           cycle_type;
    sub_def_t              another_type_reference;
    logic [HERO_WIDTH-1:0] data;
  } hero_write_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVERLONG,
    ERR_SUB_MISMATCH
  } HERO_RX_ERR_E;

  typedef struct packed {
    logic [HERO_WIDTH-1:0]  dat;
    sub_def_t               sub;
    logic [IDX_FIELD_W-1:0] idx;
    logic                   last;
  } hero_rx_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } hero_rx_state_e;

endpackage

// File: rtl/hero_rx_fifo.sv
// Show-ahead synchronous FIFO of receiver entries; the head entry is visible
// on o_data whenever the FIFO is non-empty and reads as zero otherwise.
module hero_rx_fifo
  import hero_write_rx_pkg::*;
#(
  parameter int DEPTH = HERO_FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_push,
  input  hero_rx_entry_t i_data,
  input  logic           i_pop,
  output hero_rx_entry_t o_data,
  output logic           o_empty,
  output logic           o_full
);

  localparam int AW = $clog2(DEPTH);

  hero_rx_entry_t r_mem [DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [AW:0]    r_count;
  logic           w_doPush;
  logic           w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = o_empty ? '0 : r_mem[r_rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/hero_write_rx.sv
// Hero write bus receiver: frames beats into transactions, tags them with
// sub/index/last, buffers them and flags protocol errors.
module hero_write_rx
  import hero_write_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = HERO_FIFO_DEPTH,
  parameter int MAX_BEATS  = HERO_MAX_BEATS,
  localparam int IDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  hero_write_t           hero_wr,
  output logic                  hero_rdy,
  output logic                  rx_vld,
  input  logic                  rx_rdy,
  output logic [HERO_WIDTH-1:0] rx_dat,
  output sub_def_t              rx_sub,
  output logic [IDX_W-1:0]      rx_idx,
  output logic                  rx_last,
  output logic                  err_vld,
  output HERO_RX_ERR_E          err_code,
  output logic [15:0]           txn_cnt
);

  hero_rx_state_e r_state, w_nextState;
  logic [IDX_W-1:0] r_beatCnt, w_nextBeatCnt;
  sub_def_t         r_sub, w_nextSub;
  logic             r_errVld;
  HERO_RX_ERR_E     r_errCode;
  logic [15:0]      r_txnCnt;

  logic             w_isBeat, w_accept, w_pop, w_full, w_empty;
  logic             w_first, w_last, w_overlong, w_mismatch, w_errEvt;
  logic [IDX_W-1:0] w_beatIdx;
  sub_def_t         w_beatSub;
  HERO_RX_ERR_E     w_errCode;
  hero_rx_entry_t   w_pushEntry, w_headEntry;
  logic             w_unusedIdx;

  assign w_isBeat = hero_wr.clk_en &&
                    (hero_wr.cycle_type == HERO_VALID || hero_wr.cycle_type == HERO_DONE);
  // Held low while in reset so nothing is taken before the FIFO is cleared.
  assign hero_rdy = rst_n && !w_full;
  assign w_accept = hero_rdy && w_isBeat;
  assign rx_vld   = !w_empty;
  assign w_pop    = rx_vld && rx_rdy;

  always_comb begin
    w_nextState   = r_state;
    w_nextBeatCnt = r_beatCnt;
    w_nextSub     = r_sub;
    w_errEvt      = 1'b0;
    w_errCode     = ERR_NONE;
    w_first       = (r_state == ST_IDLE);
    w_beatIdx     = w_first ? '0 : r_beatCnt;
    w_beatSub     = w_first ? hero_wr.another_type_reference : r_sub;
    w_overlong    = (hero_wr.cycle_type == HERO_VALID) && (w_beatIdx == IDX_W'(MAX_BEATS - 1));
    w_mismatch    = !w_first && (hero_wr.another_type_reference != r_sub);
    w_last        = (hero_wr.cycle_type == HERO_DONE) || w_overlong;
    w_pushEntry.dat  = hero_wr.data;
    w_pushEntry.sub  = w_beatSub;
    w_pushEntry.idx  = IDX_FIELD_W'(w_beatIdx);
    w_pushEntry.last = w_last;
    if (w_accept) begin
      w_nextSub = w_beatSub;
      if (w_last) begin
        w_nextState   = ST_IDLE;
        w_nextBeatCnt = '0;
      end else begin
        w_nextState   = ST_XFER;
        w_nextBeatCnt = w_beatIdx + IDX_W'(1);
      end
      // An overlong beat that also mismatches reports the overlong cause.
      if (w_overlong) begin
        w_errEvt  = 1'b1;
        w_errCode = ERR_OVERLONG;
      end else if (w_mismatch) begin
        w_errEvt  = 1'b1;
        w_errCode = ERR_SUB_MISMATCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_beatCnt <= '0;
      r_sub     <= '0;
      r_errVld  <= 1'b0;
      r_errCode <= ERR_NONE;
      r_txnCnt  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_beatCnt <= w_nextBeatCnt;
      r_sub     <= w_nextSub;
      r_errVld  <= w_errEvt;
      if (w_errEvt) r_errCode <= w_errCode;
      if (w_pop && w_headEntry.last && r_txnCnt != 16'hFFFF) r_txnCnt <= r_txnCnt + 16'd1;
    end
  end

  hero_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_data  (w_pushEntry),
    .i_pop   (w_pop),
    .o_data  (w_headEntry),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign rx_dat      = w_headEntry.dat;
  assign rx_sub      = w_headEntry.sub;
  assign rx_idx      = w_headEntry.idx[IDX_W-1:0];
  assign rx_last     = w_headEntry.last;
  assign err_vld     = r_errVld;
  assign err_code    = r_errCode;
  assign txn_cnt     = r_txnCnt;
  // Upper index bits are always zero; folded here so they count as read.
  assign w_unusedIdx = |w_headEntry.idx;

endmodule
